uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 146 ++++++++++++++
 tb/tb_uart_receiver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// Purpose: 8N1 LSB-first UART receiver with a single-byte ready/valid holding register.
// Latency: byte valid 2+SampleTime+9*SymbolEdgeTime clocks after the first edge that samples the start bit low.
// Backpressure: a good frame arriving while the held byte is unread is dropped and flagged by Overrun.
module uart_receiver #(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       SIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  output logic       FrameError,
  output logic       Overrun
);

  localparam int SymbolEdgeTime    = ClockFreq / BaudRate;
  localparam int SampleTime        = SymbolEdgeTime / 2;
  localparam int ClockCounterWidth = $clog2(SymbolEdgeTime);

  localparam logic [ClockCounterWidth-1:0] SampleLast = ClockCounterWidth'(SampleTime - 1);
  localparam logic [ClockCounterWidth-1:0] EdgeLast   = ClockCounterWidth'(SymbolEdgeTime - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                       state, state_nxt;
  logic                         sin_meta, sin_sync;
  logic [ClockCounterWidth-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]                   bit_cnt, bit_cnt_nxt;
  logic [7:0]                   shift, shift_nxt;
  logic [7:0]                   data_nxt;
  logic                         valid_nxt;
  logic                         frame_err_nxt;
  logic                         overrun_nxt;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sin_meta <= 1'b1;
      sin_sync <= 1'b1;
    end else begin
      sin_meta <= SIn;
      sin_sync <= sin_meta;
    end
  end

  // State, counters, shift register, holding register and registered flag pulses.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      DataOut      <= '0;
      DataOutValid <= 1'b0;
      FrameError   <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      clk_cnt      <= clk_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift        <= shift_nxt;
      DataOut      <= data_nxt;
      DataOutValid <= valid_nxt;
      FrameError   <= frame_err_nxt;
      Overrun      <= overrun_nxt;
    end
  end

  // Next-state logic: bit timing, sampling, frame checks and holding-register update.
  always_comb begin
    state_nxt     = state;
    clk_cnt_nxt   = clk_cnt;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    data_nxt      = DataOut;
    valid_nxt     = DataOutValid & ~DataOutReady;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (!sin_sync) state_nxt = START;
      end
      START: begin
        clk_cnt_nxt = clk_cnt + 1'b1;
        if (clk_cnt == SampleLast) begin
          clk_cnt_nxt = '0;
          if (!sin_sync) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            // Start bit vanished before its midpoint: treat as line noise.
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        clk_cnt_nxt = clk_cnt + 1'b1;
        if (clk_cnt == EdgeLast) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {sin_sync, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        clk_cnt_nxt = clk_cnt + 1'b1;
        if (clk_cnt == EdgeLast) begin
          clk_cnt_nxt = '0;
          if (sin_sync) begin
            state_nxt = IDLE;
            // The slot is free if empty or being drained on this same edge.
            if (!DataOutValid || DataOutReady) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
            end else begin
              overrun_nxt = 1'b1;
            end
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must return high before a new start bit counts.
        clk_cnt_nxt = '0;
        if (sin_sync) state_nxt = IDLE;
      end
      default: begin
        clk_cnt_nxt = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed scenarios plus random bytes, checked against a frame-level model.
// Runs the receiver at 300 clocks per bit so the whole sequence stays short.
// Consumption is either manual or automatic with a random delay below 100 cycles.
module tb_uart_receiver;

  localparam int ClkHz   = 34_560_000;
  localparam int Baud    = 115_200;
  localparam int BitT    = ClkHz / Baud;
  localparam int HalfT   = BitT / 2;
  localparam int DoneLat = 2 + HalfT + 9 * BitT;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic       SIn;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;
  logic       FrameError;
  logic       Overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         rise_q[$];
  int         fe_q[$];
  int         ov_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  logic prev_valid   = 1'b0;
  logic auto_consume = 1'b0;
  logic auto_rdy     = 1'b0;
  logic man_rdy      = 1'b0;
  int   wait_cnt     = 0;
  int   wait_tgt     = 0;

  assign DataOutReady = auto_consume ? auto_rdy : man_rdy;

  uart_receiver #(
    .ClockFreq(ClkHz),
    .BaudRate (Baud)
  ) dut (
    .Clock       (Clock),
    .ResetN      (ResetN),
    .SIn         (SIn),
    .DataOut     (DataOut),
    .DataOutValid(DataOutValid),
    .DataOutReady(DataOutReady),
    .FrameError  (FrameError),
    .Overrun     (Overrun)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc++;

  // Event recorder and optional automatic consumer, both on the falling edge.
  always @(negedge Clock) begin
    if (DataOutValid && !prev_valid) rise_q.push_back(cyc);
    prev_valid = DataOutValid;
    if (FrameError) fe_q.push_back(cyc);
    if (Overrun) ov_q.push_back(cyc);
    if (auto_rdy) begin
      auto_rdy = 1'b0;
    end else if (auto_consume && DataOutValid) begin
      if (wait_cnt >= wait_tgt) begin
        auto_rdy = 1'b1;
        rx_q.push_back(DataOut);
        wait_cnt = 0;
        wait_tgt = $urandom_range(0, 90);
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Drives one frame starting at the current falling edge; e0 is the first edge that sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low, output int e0);
    SIn = 1'b0;
    e0  = cyc + 1;
    repeat (BitT) @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      SIn = b[i];
      repeat (BitT) @(negedge Clock);
    end
    SIn = stop;
    repeat (BitT) @(negedge Clock);
    if (extra_low > 0) begin
      SIn = 1'b0;
      repeat (extra_low * BitT) @(negedge Clock);
    end
    SIn = 1'b1;
  endtask

  task automatic clear_logs();
    rise_q.delete();
    fe_q.delete();
    ov_q.delete();
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         e0;
    int         e0b;
    int         exp_fe;
    logic [7:0] b;
    logic [7:0] b2;
    logic       good;

    ResetN = 1'b0;
    SIn    = 1'b1;
    idle(4);
    check("reset_data",  32'(DataOut), 32'h0);
    check("reset_valid", 32'(DataOutValid), 32'h0);
    check("reset_fe",    32'(FrameError), 32'h0);
    check("reset_ov",    32'(Overrun), 32'h0);
    ResetN = 1'b1;
    idle(10);
    clear_logs();

    // Single byte, held unread, then one-cycle consume.
    send_frame(8'hA5, 1'b1, 0, e0);
    idle(5);
    check("t1_rise_cnt", 32'(rise_q.size()), 32'd1);
    check("t1_rise_cyc", 32'(rise_q.size() > 0 ? rise_q[0] : -1), 32'(e0 + DoneLat));
    check("t1_data",     32'(DataOut), 32'hA5);
    check("t1_fe_cnt",   32'(fe_q.size()), 32'd0);
    check("t1_ov_cnt",   32'(ov_q.size()), 32'd0);
    man_rdy = 1'b1;
    @(negedge Clock);
    man_rdy = 1'b0;
    check("t1_valid_after_rdy", 32'(DataOutValid), 32'h0);
    idle(10);
    clear_logs();

    // Back-to-back frames with no idle gap, consumed automatically.
    auto_consume = 1'b1;
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 0, e0);
    idle(150);
    check("t2_rx_cnt", 32'(rx_q.size()), 32'd3);
    foreach (exp_q[i]) check("t2_rx_byte", 32'(rx_q.size() > i ? rx_q[i] : 8'hxx), 32'(exp_q[i]));
    check("t2_fe_cnt", 32'(fe_q.size()), 32'd0);
    check("t2_ov_cnt", 32'(ov_q.size()), 32'd0);
    clear_logs();

    // Overrun: second byte arrives while the first is still held.
    auto_consume = 1'b0;
    send_frame(8'h11, 1'b1, 0, e0);
    send_frame(8'h22, 1'b1, 0, e0b);
    idle(5);
    check("t3_ov_cnt",  32'(ov_q.size()), 32'd1);
    check("t3_ov_cyc",  32'(ov_q.size() > 0 ? ov_q[0] : -1), 32'(e0b + DoneLat));
    check("t3_data",    32'(DataOut), 32'h11);
    check("t3_valid",   32'(DataOutValid), 32'h1);
    check("t3_rise",    32'(rise_q.size()), 32'd1);
    check("t3_fe_cnt",  32'(fe_q.size()), 32'd0);
    man_rdy = 1'b1;
    @(negedge Clock);
    man_rdy = 1'b0;
    idle(10);
    clear_logs();

    // Framing error followed by a break, then a good frame.
    auto_consume = 1'b1;
    send_frame(8'h55, 1'b0, 2, e0);
    idle(10);
    send_frame(8'h66, 1'b1, 0, e0b);
    idle(150);
    check("t4_fe_cnt", 32'(fe_q.size()), 32'd1);
    check("t4_fe_cyc", 32'(fe_q.size() > 0 ? fe_q[0] : -1), 32'(e0 + DoneLat));
    check("t4_rise",   32'(rise_q.size()), 32'd1);
    check("t4_rx_cnt", 32'(rx_q.size()), 32'd1);
    check("t4_rx",     32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'h66);
    check("t4_ov_cnt", 32'(ov_q.size()), 32'd0);
    clear_logs();

    // Short low glitch shorter than half a bit: no output, receiver stays usable.
    SIn = 1'b0;
    idle(100);
    SIn = 1'b1;
    idle(3 * BitT);
    check("t5_glitch_rise",  32'(rise_q.size()), 32'd0);
    check("t5_glitch_fe",    32'(fe_q.size()), 32'd0);
    check("t5_glitch_ov",    32'(ov_q.size()), 32'd0);
    check("t5_glitch_valid", 32'(DataOutValid), 32'h0);
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, 0, e0);
    idle(150);
    check("t5_after_glitch", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'(b));
    clear_logs();

    // Reset during bit 4 while a byte is held.
    auto_consume = 1'b0;
    b = 8'($urandom_range(1, 255));
    send_frame(b, 1'b1, 0, e0);
    idle(5);
    check("t6_held", 32'(DataOut), 32'(b));
    b2 = 8'($urandom_range(0, 255));
    SIn = 1'b0;
    idle(BitT);
    for (int i = 0; i < 4; i++) begin
      SIn = b2[i];
      idle(BitT);
    end
    SIn = b2[4];
    idle(HalfT);
    ResetN = 1'b0;
    @(negedge Clock);
    check("t6_rst_data",  32'(DataOut), 32'h0);
    check("t6_rst_valid", 32'(DataOutValid), 32'h0);
    check("t6_rst_fe",    32'(FrameError), 32'h0);
    check("t6_rst_ov",    32'(Overrun), 32'h0);
    idle(3);
    SIn = 1'b1;
    ResetN = 1'b1;
    idle(20);
    check("t6_post_valid", 32'(DataOutValid), 32'h0);
    clear_logs();
    auto_consume = 1'b1;
    send_frame(b2, 1'b1, 0, e0);
    idle(150);
    check("t6_rx_cnt", 32'(rx_q.size()), 32'd1);
    check("t6_rx",     32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'(b2));
    check("t6_fe_cnt", 32'(fe_q.size()), 32'd0);
    clear_logs();

    // Random frames, some with a bad stop bit; the model keeps only good-stop bytes.
    exp_fe = 0;
    for (int n = 0; n < 3; n++) begin
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      send_frame(b, good, 0, e0);
      idle(10);
      if (good) exp_q.push_back(b);
      else exp_fe++;
    end
    idle(150);
    check("t7_rx_cnt", 32'(rx_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) check("t7_rx_byte", 32'(rx_q.size() > i ? rx_q[i] : 8'hxx), 32'(exp_q[i]));
    check("t7_fe_cnt", 32'(fe_q.size()), 32'(exp_fe));
    check("t7_ov_cnt", 32'(ov_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
